pc_fetch_ctrl: RTL
==================

Name: pc_fetch_ctrl

Overview:
Instruction-fetch sequencer for the RV32I core. Owns the PC register and drives instruction memory through a req/gnt/rvalid handshake with at most one request outstanding. Holds one fetched instruction in a single-entry output buffer for decode. Applies taken-branch/jump redirects from execute, including squashing stale in-flight responses, and honours stalls from the hazard unit.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
XLEN, 32, PC/address/instruction width (only 32 supported)

Ports:
clk  in  1  core clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
stall_i  in  1  decode cannot accept; hold output buffer
redirect_i  in  1  execute resolved taken branch/jump (PCsrc)
redirect_target_i  in  32  new PC (PC+ImmOp or jalr target)
imem_req_o  out  1  fetch request
imem_addr_o  out  32  fetch address, word aligned
imem_gnt_i  in  1  memory accepted request this cycle
imem_rvalid_i  in  1  response data valid (≥1 cycle after gnt)
imem_rdata_i  in  32  fetched instruction
instr_valid_o  out  1  output buffer holds a valid instruction
instr_o  out  32  buffered instruction
instr_pc_o  out  32  PC of buffered instruction
misaligned_o  out  1  redirect target had bits[1:0]!=0 (see Optional Feature)

Behaviour:
- Reset (rst=1 at a clock edge): pc=RESET_PC; state=IDLE; buffer empty; req_pending=0. Outputs: instr_valid_o=0, instr_o=32'h0000_0013 (NOP), instr_pc_o=0, imem_req_o=0, misaligned_o=0. Reset mid-transaction abandons any in-flight response; memory must drop it.
- States: IDLE, REQ, WAIT, DROP.
- IDLE -> REQ unconditionally. First request is issued 1 cycle after reset deasserts.
- REQ:
  - imem_req_o = req_pending | !buf_valid | consume.
  - consume = instr_valid_o & !stall_i.
  - imem_addr_o = pc.
  - Once req is high without gnt, req_pending=1 holds the request and its address stable regardless of stall. Only redirect may withdraw it.
  - req & gnt -> WAIT; inflight_pc=pc; req_pending cleared.
- WAIT: on imem_rvalid_i:
  - buffer loads {rdata, inflight_pc}; instr_valid_o=1 next cycle;
  - pc = inflight_pc + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0);
  - -> REQ.
- Buffer consumption: buffer empties on consume unless it is reloaded the same cycle. Buffer contents hold while stall_i=1.
- Redirect (redirect_i=1, priority over all except rst):
  - pc = {target[31:2],2'b00}; buffer cleared next cycle; req_pending cleared.
  - In REQ without gnt: stay REQ; the new address is presented next cycle.
  - In REQ with gnt same cycle: -> DROP.
  - In WAIT without rvalid: -> DROP.
  - In WAIT with rvalid same cycle: response discarded, -> REQ.
  - In DROP: stay DROP with the updated pc.
  - In IDLE: pc updated, -> REQ.
  - Redirect with stall_i=1: redirect wins and the buffer is still flushed.
- DROP: imem_req_o=0. The next rvalid is discarded (no buffer load, pc unchanged), then -> REQ.
- Throughput: 2 cycles per instruction with zero-wait memory (gnt same cycle as req, rvalid next cycle). Load-to-instr_valid_o latency is 1 cycle after rvalid.
- rvalid outside WAIT/DROP is a protocol error and is ignored.

Optional Feature:
PC_ALIGN_CHECK_EN.
- Defined: on redirect_i with target[1:0]!=0, misaligned_o pulses high for exactly 1 cycle, registered (cycle after redirect). The target is still masked and fetch proceeds.
- Undefined: misaligned_o tied 0 and bits[1:0] are masked silently. The port is present in both builds.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {IDLE,REQ,WAIT,DROP};
  - INSTR_NOP=32'h0000_0013;
  - PC_INC=32'd4.
- One sub-module, pc_next_sel: combinational next-pc priority (rst > redirect > rvalid increment > hold), including alignment masking and the misalign flag.
- The FSM and buffer stay in pc_fetch_ctrl.

Test Plan:
- Reset, zero-wait memory returning addr as data -> first req at addr 0 cycle 1; instr_pc_o sequence 0,4,8 with instr_valid_o every 2 cycles.
- stall_i=1 for 5 cycles with buffer full -> instr_o/instr_pc_o unchanged; no new req issued. A req raised before the stall stays high with a stable address until gnt.
- Redirect to 32'h100 while in WAIT (rvalid 3 cycles later) -> that response dropped; next req addr 32'h100; no instr_valid_o for the old PC.
- Redirect to 32'h200 in the same cycle as rvalid -> data discarded; req to 32'h200 next cycle (no DROP).
- PC 32'hFFFF_FFFC fetched -> next req addr 32'h0000_0000.
- Redirect target 32'h0000_0106 with PC_ALIGN_CHECK_EN -> fetch from 32'h104; misaligned_o high for 1 cycle. Without the macro -> same fetch, misaligned_o=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [31:0] PC_INC    = 32'd4;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority select: rst > redirect > response increment > hold.
// PC_ALIGN_CHECK_EN enables the misaligned-redirect flag; otherwise it stays 0.
module pc_next_sel
    import fetch_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic [XLEN-1:0] cur_pc,
    input  logic [XLEN-1:0] base_pc,
    input  logic            rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] target,
    input  logic            inc_en,
    output logic [XLEN-1:0] pc_next,
    output logic            misalign
);

`ifdef PC_ALIGN_CHECK_EN
    localparam logic CHECK_EN = 1'b1;
`else
    localparam logic CHECK_EN = 1'b0;
`endif

    always_comb begin
        pc_next  = cur_pc;
        misalign = 1'b0;
        if (rst) begin
            pc_next = RESET_PC;
        end else if (redirect) begin
            // Low bits are always masked; the flag only reports that they were set.
            pc_next  = {target[XLEN-1:2], 2'b00};
            misalign = CHECK_EN & (|target[1:0]);
        end else if (inc_en) begin
            pc_next = base_pc + PC_INC;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the imem req/gnt/rvalid handshake
// and holds one instruction for decode. Optional macro: PC_ALIGN_CHECK_EN.
//
// state | meaning
// IDLE  | one cycle after reset before the first request
// REQ   | request presented (or waiting for buffer space)
// WAIT  | granted, waiting for the response
// DROP  | a redirect orphaned an in-flight response; discard it
module pc_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_target_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic            misaligned_o
);

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] pc, pc_next;
    logic [XLEN-1:0] inflight_pc, inflight_next;
    logic            req_pending, pending_next;
    logic            buf_valid;
    logic [XLEN-1:0] buf_instr, buf_pc;
    logic            misaligned_q, misalign_next;
    logic            consume, req, load, inc_en;

    pc_next_sel #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_next_sel (
        .cur_pc   (pc),
        .base_pc  (inflight_pc),
        .rst      (rst),
        .redirect (redirect_i),
        .target   (redirect_target_i),
        .inc_en   (inc_en),
        .pc_next  (pc_next),
        .misalign (misalign_next)
    );

    always_comb begin
        consume       = buf_valid & ~stall_i;
        req           = (state == REQ) & (req_pending | ~buf_valid | consume);
        load          = (state == WAIT) & imem_rvalid_i & ~redirect_i;
        inc_en        = (state == WAIT) & imem_rvalid_i;
        state_next    = state;
        pending_next  = req_pending;
        inflight_next = inflight_pc;
        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                if (req && imem_gnt_i) begin
                    inflight_next = pc;
                    pending_next  = 1'b0;
                    state_next    = redirect_i ? DROP : WAIT;
                end else if (redirect_i) begin
                    pending_next = 1'b0;
                end else if (req) begin
                    // Once raised, the request stays up until granted or redirected.
                    pending_next = 1'b1;
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    state_next = REQ;
                end else if (redirect_i) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid_i) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        pc           <= pc_next;
        misaligned_q <= misalign_next;
        if (rst) begin
            state       <= IDLE;
            req_pending <= 1'b0;
            inflight_pc <= '0;
            buf_valid   <= 1'b0;
            buf_instr   <= INSTR_NOP;
            buf_pc      <= '0;
        end else begin
            state       <= state_next;
            req_pending <= pending_next;
            inflight_pc <= inflight_next;
            if (redirect_i) begin
                buf_valid <= 1'b0;
            end else if (load) begin
                buf_valid <= 1'b1;
                buf_instr <= imem_rdata_i;
                buf_pc    <= inflight_pc;
            end else if (consume) begin
                buf_valid <= 1'b0;
            end
        end
    end

    assign imem_req_o    = req;
    assign imem_addr_o   = pc;
    assign instr_valid_o = buf_valid;
    assign instr_o       = buf_instr;
    assign instr_pc_o    = buf_pc;
    assign misaligned_o  = misaligned_q;

endmodule
